// File: rtl/muldiv_sequencer.sv
// Multi-cycle 32x32 shift-add multiply and 32/32 restoring divide that borrows an external ALU.
// Define SIGNED_MULDIV_EN to add op_signed and the PRE_A/PRE_B/POST_1..3 sign fix-up states.
`ifndef ADDU
`define ADDU 4'd0
`endif
`ifndef SUBU
`define SUBU 4'd1
`endif
`ifndef NEG
`define NEG 4'd2
`endif
`ifndef NOT
`define NOT 4'd3
`endif

module muldiv_sequencer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            op_div,
`ifdef SIGNED_MULDIV_EN
  input  logic            op_signed,
`endif
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_zero,
  input  logic            alu_overflow,
  input  logic            alu_negative
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RUN, S_FIN
`ifdef SIGNED_MULDIV_EN
    , S_PRE_A, S_PRE_B, S_POST_1, S_POST_2, S_POST_3
`endif
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              div_q, dz;
  logic [XLEN-1:0]   mcand, ph, pl;
  logic [XLEN-1:0]   mcand_nx, ph_nx, pl_nx, rem_sh;
  logic              msb, last, start_dz;
  logic              unused_zero;
`ifdef SIGNED_MULDIV_EN
  logic              sgn, sa, sb, carry, neg_res;
  assign neg_res = sa ^ sb;
`endif

  assign start_dz    = op_div && (b_in == '0);
  assign last        = (cnt == CNT_LAST);
  assign msb         = ph[XLEN-1];
  assign rem_sh      = {ph[XLEN-2:0], pl[XLEN-1]};
  assign unused_zero = alu_zero;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_RUN;
`ifdef SIGNED_MULDIV_EN
        if (start && op_signed && !start_dz) state_nx = S_PRE_A;
`endif
      end
      S_RUN: begin
        if (last) state_nx = S_FIN;
`ifdef SIGNED_MULDIV_EN
        if (last && sgn && !dz) state_nx = S_POST_1;
`endif
      end
      S_FIN:    state_nx = S_IDLE;
`ifdef SIGNED_MULDIV_EN
      S_PRE_A:  state_nx = S_PRE_B;
      S_PRE_B:  state_nx = S_RUN;
      S_POST_1: state_nx = S_POST_2;
      S_POST_2: state_nx = S_POST_3;
      S_POST_3: state_nx = S_FIN;
`endif
      default:  state_nx = S_IDLE;
    endcase
  end

  // ALU request: operands and opcode presented for the current state
  always_comb begin
    alu_op = `ADDU;
    alu_a  = '0;
    alu_b  = '0;
    case (state)
      S_RUN: begin
        if (!dz && div_q) begin
          alu_op = `SUBU;
          alu_a  = rem_sh;
          alu_b  = mcand;
        end else if (!dz) begin
          alu_a  = ph;
          alu_b  = mcand;
        end
      end
`ifdef SIGNED_MULDIV_EN
      S_PRE_A: begin
        alu_op = `NEG;
        alu_a  = div_q ? pl : mcand;
      end
      S_PRE_B: begin
        alu_op = `NEG;
        alu_a  = div_q ? mcand : pl;
      end
      S_POST_1: begin
        alu_op = `NEG;
        alu_a  = pl;
      end
      S_POST_2: begin
        alu_op = div_q ? `NEG : `NOT;
        alu_a  = ph;
      end
      S_POST_3: begin
        if (!div_q) begin
          alu_a = ph;
          alu_b = XLEN'(carry);
        end
      end
`endif
      default: ;
    endcase
  end

  // Datapath next values; a divide-by-zero request idles through its single RUN cycle
  always_comb begin
    mcand_nx = mcand;
    ph_nx    = ph;
    pl_nx    = pl;
    case (state)
      S_RUN: begin
        if (!dz && div_q) begin
          if (msb || !alu_negative) begin
            ph_nx = alu_out;
            pl_nx = {pl[XLEN-2:0], 1'b1};
          end else begin
            ph_nx = rem_sh;
            pl_nx = {pl[XLEN-2:0], 1'b0};
          end
        end else if (!dz) begin
          if (pl[0]) {ph_nx, pl_nx} = {alu_overflow, alu_out, pl[XLEN-1:1]};
          else       {ph_nx, pl_nx} = {1'b0, ph, pl[XLEN-1:1]};
        end
      end
`ifdef SIGNED_MULDIV_EN
      S_PRE_A: begin
        if (sa && div_q) pl_nx    = alu_out;
        if (sa && !div_q) mcand_nx = alu_out;
      end
      S_PRE_B: begin
        if (sb && div_q) mcand_nx = alu_out;
        if (sb && !div_q) pl_nx    = alu_out;
      end
      S_POST_1: if (neg_res) pl_nx = alu_out;
      S_POST_2: if (div_q ? sa : neg_res) ph_nx = alu_out;
      S_POST_3: if (!div_q && neg_res) ph_nx = alu_out;
`endif
      default: ;
    endcase
  end

  // Operand latch, iteration counter and registered results
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      div_q       <= 1'b0;
      dz          <= 1'b0;
      mcand       <= '0;
      ph          <= '0;
      pl          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
`ifdef SIGNED_MULDIV_EN
      sgn         <= 1'b0;
      sa          <= 1'b0;
      sb          <= 1'b0;
      carry       <= 1'b0;
`endif
    end else begin
      mcand <= mcand_nx;
      ph    <= ph_nx;
      pl    <= pl_nx;
      done  <= 1'b0;
      if (state == S_RUN) cnt <= cnt + CNT_W'(1);
      if (state == S_IDLE && start) begin
        busy  <= 1'b1;
        div_q <= op_div;
        dz    <= start_dz;
        if (start_dz) begin
          cnt <= CNT_LAST;
          ph  <= a_in;
          pl  <= '1;
        end else begin
          cnt   <= '0;
          ph    <= '0;
          pl    <= op_div ? a_in : b_in;
          mcand <= op_div ? b_in : a_in;
        end
`ifdef SIGNED_MULDIV_EN
        sgn   <= op_signed;
        sa    <= a_in[XLEN-1];
        sb    <= b_in[XLEN-1];
        carry <= 1'b0;
`endif
      end
`ifdef SIGNED_MULDIV_EN
      if (state == S_POST_1) carry <= alu_zero;
`endif
      if (state_nx == S_FIN) begin
        busy        <= 1'b0;
        done        <= 1'b1;
        hi          <= ph_nx;
        lo          <= pl_nx;
        div_by_zero <= dz;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: acts as the ALU, applies a directed table,
// hand-written reset/handshake sequences and random operations against an arithmetic model.
`ifndef ADDU
`define ADDU 4'd0
`endif
`ifndef SUBU
`define SUBU 4'd1
`endif
`ifndef NEG
`define NEG 4'd2
`endif
`ifndef NOT
`define NOT 4'd3
`endif

module tb_muldiv_sequencer;
  logic        clk, rst, start, op_div;
  logic [31:0] a_in, b_in, hi, lo, alu_a, alu_b, alu_out;
  logic        busy, done, div_by_zero, alu_zero, alu_overflow, alu_negative;
  logic [3:0]  alu_op;
`ifdef SIGNED_MULDIV_EN
  logic        op_signed;
`endif

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    logic        dv;
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;
  vec_t tbl[$];

  muldiv_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op_div(op_div),
`ifdef SIGNED_MULDIV_EN
    .op_signed(op_signed),
`endif
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_negative(alu_negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU answering the sequencer in the same cycle
  always_comb begin
    alu_out      = '0;
    alu_overflow = 1'b0;
    alu_negative = 1'b0;
    case (alu_op)
      `ADDU: {alu_overflow, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      `SUBU: {alu_negative, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
      `NEG:  alu_out = 32'd0 - alu_a;
      `NOT:  alu_out = ~alu_a;
      default: ;
    endcase
    alu_zero = (alu_out == '0);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic
  task automatic model(input logic dv, input logic sg, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l, output logic z);
    logic signed [63:0] sa, sb, sp, sq, sr;
    logic [63:0] up;
    sa = 64'($signed(a));
    sb = 64'($signed(b));
    z  = 1'b0;
    if (dv && b == 32'd0) begin
      h = a; l = 32'hFFFF_FFFF; z = 1'b1;
    end else if (!dv) begin
      if (sg) begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
      else begin up = {32'd0, a} * {32'd0, b}; h = up[63:32]; l = up[31:0]; end
    end else if (sg) begin
      sq = sa / sb; sr = sa % sb; l = sq[31:0]; h = sr[31:0];
    end else begin
      l = a / b; h = a % b;
    end
  endtask

  // One operation: start accepted at the next posedge; cycle 1 is the cycle after that edge
  task automatic do_op(input logic dv, input logic sg, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l, output logic z,
                       output int lat, output logic busy_ok);
    @(negedge clk);
    start = 1'b1; op_div = dv; a_in = a; b_in = b;
`ifdef SIGNED_MULDIV_EN
    op_signed = sg;
`endif
    @(posedge clk);
    #1;
    start = 1'b0; op_div = ~dv; a_in = $urandom; b_in = $urandom;
`ifdef SIGNED_MULDIV_EN
    op_signed = ~sg;
`endif
    lat = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    h = hi; l = lo; z = div_by_zero;
  endtask

  task automatic op_check(input string nm, input logic dv, input logic sg,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input logic ez,
                          input int elat);
    logic [31:0] h, l;
    logic z, bok;
    int lat;
    do_op(dv, sg, a, b, h, l, z, lat, bok);
    check({nm, ".hi"}, 64'(h), 64'(eh));
    check({nm, ".lo"}, 64'(l), 64'(el));
    check({nm, ".dz"}, 64'(z), 64'(ez));
    check({nm, ".lat"}, 64'(lat), 64'(elat));
    check({nm, ".busy"}, 64'(bok), 64'(1));
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, ".busy"}, 64'(busy), 64'(0));
    check({nm, ".done"}, 64'(done), 64'(0));
    check({nm, ".dz"}, 64'(div_by_zero), 64'(0));
    check({nm, ".hi"}, 64'(hi), 64'(0));
    check({nm, ".lo"}, 64'(lo), 64'(0));
    check({nm, ".alu_op"}, 64'(alu_op), 64'(`ADDU));
    check({nm, ".alu_a"}, 64'(alu_a), 64'(0));
    check({nm, ".alu_b"}, 64'(alu_b), 64'(0));
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp[4];
    sp[0] = 32'h0; sp[1] = 32'h1; sp[2] = 32'hFFFF_FFFF; sp[3] = 32'h8000_0000;
    case ($urandom % 4)
      0: pick = sp[$urandom % 4];
      1: pick = 32'($urandom % 64);
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] h, l, eh, el;
    logic z, ez, bok, dv, sg;
    int lat, ndone, elat;

    rst = 1'b1; start = 1'b0; op_div = 1'b0; a_in = '0; b_in = '0;
`ifdef SIGNED_MULDIV_EN
    op_signed = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    tbl.push_back('{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33});
    tbl.push_back('{1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33});
    tbl.push_back('{1'b1, 1'b0, 32'h8000_0001, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0, 1'b0, 33});
    tbl.push_back('{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 1'b0, 33});
    tbl.push_back('{1'b1, 1'b0, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 1'b1, 2});
`ifdef SIGNED_MULDIV_EN
    tbl.push_back('{1'b0, 1'b1, -32'sd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 38});
    tbl.push_back('{1'b1, 1'b1, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 38});
    tbl.push_back('{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 38});
    tbl.push_back('{1'b1, 1'b1, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 1'b1, 2});
`endif
    foreach (tbl[i])
      op_check($sformatf("tbl%0d", i), tbl[i].dv, tbl[i].sg, tbl[i].a, tbl[i].b,
               tbl[i].hi, tbl[i].lo, tbl[i].dz, tbl[i].lat);

    // start pulsed while busy must be ignored
    @(negedge clk);
    start = 1'b1; op_div = 1'b1; a_in = 32'd100; b_in = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = (k == 5);
      op_div = 1'b0; a_in = 32'd3; b_in = 32'd5;
      if (done) begin lat = k; break; end
    end
    start = 1'b0;
    check("ign.hi", 64'(hi), 64'(32'd2));
    check("ign.lo", 64'(lo), 64'(32'd14));
    check("ign.lat", 64'(lat), 64'(33));
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ign.extra_done", 64'(ndone), 64'(0));

    // reset in the middle of a multiply
    @(negedge clk);
    start = 1'b1; op_div = 1'b0; a_in = 32'hFFFF_FFFF; b_in = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    check("rstmid.busy_before", 64'(busy), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rstmid");
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("rstmid.no_done", 64'(ndone), 64'(0));

    // random operations against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      dv = 1'($urandom % 2);
      sg = 1'b0;
`ifdef SIGNED_MULDIV_EN
      sg = 1'($urandom % 2);
`endif
      a_in = pick();
      b_in = ($urandom % 8 == 0) ? 32'd0 : pick();
      begin
        logic [31:0] ra, rb;
        ra = a_in; rb = b_in;
        model(dv, sg, ra, rb, eh, el, ez);
        elat = ez ? 2 : (sg ? 38 : 33);
        do_op(dv, sg, ra, rb, h, l, z, lat, bok);
        check($sformatf("rnd%0d.hi", n), 64'(h), 64'(eh));
        check($sformatf("rnd%0d.lo", n), 64'(l), 64'(el));
        check($sformatf("rnd%0d.dz", n), 64'(z), 64'(ez));
        check($sformatf("rnd%0d.lat", n), 64'(lat), 64'(elat));
        check($sformatf("rnd%0d.busy", n), 64'(bok), 64'(1));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle 32x32 multiply and 32/32 divide unit for the execute stage; produces HI/LO results.
- Holds no adder of its own. It is the initiator on the ALU operand/opcode interface: it drives A, B and opcode each cycle, then consumes the ALU result and zero/overflow/negative flags.
- Opcodes are the `ADDU, `SUBU, `NEG and `NOT macros from aluopdef.v.
- The pipeline stalls on busy.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- op_div  in  1  0 = multiply, 1 = divide; latched at start.
- a_in  in  32  multiplicand / dividend; latched at start.
- b_in  in  32  multiplier / divisor; latched at start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when hi/lo are valid.
- div_by_zero  out  1  valid with done; set when op_div=1 and b=0.
- hi  out  32  product[63:32] or remainder.
- lo  out  32  product[31:0] or quotient.
- alu_a  out  32  ALU operand A.
- alu_b  out  32  ALU operand B.
- alu_op  out  4  ALU opcode.
- alu_out  in  32  ALU result; same cycle, combinational.
- alu_zero  in  1  ALU zero flag.
- alu_overflow  in  1  ALU overflow flag; carry-out for `ADDU.
- alu_negative  in  1  ALU negative flag; borrow for `SUBU.

Behaviour:
- Reset: state IDLE; busy, done, div_by_zero = 0; hi, lo = 0; alu_a, alu_b = 0; alu_op = `ADDU; counter = 0.
- States: IDLE, [PRE_A, PRE_B], RUN, [POST_1, POST_2, POST_3], FIN. Bracketed states exist only with the optional feature.
- IDLE:
  - start=1 latches operands and op, sets busy, and goes to RUN.
  - If op_div=1 and b_in=0, goes directly to FIN with lo=32'hFFFFFFFF, hi=a_in, div_by_zero=1.
- RUN, multiply (shift-add, 32 cycles):
  - alu_op=`ADDU, alu_a=P_hi, alu_b=multiplicand.
  - If P_lo[0]=1: {P_hi,P_lo} <= {alu_overflow, alu_out, P_lo} >> 1.
  - Otherwise: {P_hi,P_lo} <= {1'b0, P_hi, P_lo} >> 1.
  - P_lo is initialised with the multiplier; P_hi is initialised to 0.
- RUN, divide (restoring, 32 cycles):
  - Internally form {msb, R', Q'} = {R, Q} << 1.
  - alu_op=`SUBU, alu_a=R', alu_b=divisor.
  - If msb=1 or alu_negative=0: R <= alu_out, Q <= {Q'[31:1], 1}.
  - Otherwise: R <= R', Q <= Q'.
  - Q starts as the dividend; R starts at 0.
- Counter increments each RUN cycle. Leave RUN after the cycle where counter=31. Counter wraps to 0.
- FIN: hi/lo written, done=1 and busy=0 in the same cycle, then IDLE.
- Latency: start sampled at edge t; done high during cycle t+33. The div-by-zero path gives done at t+2.
- hi, lo, div_by_zero hold their values until the next FIN.
- start while busy is ignored. Back-to-back: start may be sampled in the IDLE cycle immediately after FIN.
- rst mid-operation aborts the operation and returns to reset values; no done pulse.
- Outside RUN and the fix-up states, alu_op=`ADDU with operands 0. The ALU result is ignored.

Optional Feature:
- Macro: SIGNED_MULDIV_EN.
- With the macro defined:
  - Adds input op_signed (1 bit, latched at start).
  - When op_signed=1, PRE_A then PRE_B run with alu_op=`NEG. Each takes alu_out only if that operand's bit 31 is set.
  - After RUN, fix-up for multiply (only if a[31]^b[31]):
    - POST_1 `NEG on lo; save alu_zero as carry.
    - POST_2 `NOT on hi.
    - POST_3 `ADDU hi + carry.
  - Fix-up for divide:
    - POST_1 `NEG on quotient if a[31]^b[31].
    - POST_2 `NEG on remainder if a[31].
    - POST_3 idle.
  - All fix-up states always take one cycle, so signed latency is fixed: done at t+38.
  - Signed divide by zero behaves as unsigned (lo=FFFFFFFF, hi=a_in).
- Without the macro: no op_signed port; all operations are unsigned; the extra states do not exist.

Test Plan:
- Multiply: a=0xFFFFFFFF, b=0xFFFFFFFF -> done at t+33, hi=0xFFFFFFFE, lo=0x00000001.
- Divide: a=100, b=7 -> lo=14, hi=2, div_by_zero=0; busy high t+1..t+32.
- Divide: a=0x80000001, b=0xFFFFFFFF (exercises msb carry path) -> lo=0, hi=0x80000001. Then a=0xFFFFFFFF, b=0x80000000 -> lo=1, hi=0x7FFFFFFF.
- Divide by zero: a=0x1234, b=0 -> done at t+2, lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1.
- Reset and handshake:
  - Assert rst at t+10 of a multiply -> no done, all outputs at reset values.
  - Pulse start during busy -> ignored; result matches the first request.
- SIGNED_MULDIV_EN:
  - Multiply a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1, done at t+38.
  - Divide a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Divide a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
